// File: rtl/muldiv_sequencer_if.sv
// Decoder <-> multiply/divide sequencer bus: operation request, MTHI/MTLO writes,
// pipeline stall handshake and the HI/LO result registers.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, flush, hi_we, lo_we, wr_data,
        input  busy, stall, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush, hi_we, lo_we, wr_data,
        output busy, stall, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative one-bit-per-cycle multiply/divide sequencer owning the HI/LO pair.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they run as MULTU/DIVU.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             neg_res;
    logic             neg_rem;
    logic             dbz;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             signed_op;

`ifdef MULDIV_SIGNED_EN
    logic signed_q;
    assign signed_op = signed_q;
`else
    logic unused_op_bit;
    assign unused_op_bit = bus.op[0];
    assign signed_op     = 1'b0;
`endif

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign a_neg = signed_op & a_q[WIDTH-1];
    assign b_neg = signed_op & b_q[WIDTH-1];
    assign mag_a = a_neg ? -a_q : a_q;
    assign mag_b = b_neg ? -b_q : b_q;

    // Multiply step: multiplier sits in acc_lo and is consumed LSB first while
    // the product shifts right into it.
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;

    assign mul_add = acc_lo[0] ? addend : '0;
    assign mul_sum = {1'b0, acc_hi} + {1'b0, mul_add};

    // Restoring divide step: the shifted partial remainder is WIDTH+1 bits; after
    // a successful subtract the result always fits back into WIDTH bits.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, addend});
    assign div_sub   = div_shift[WIDTH-1:0] - addend;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign prod       = {acc_hi, acc_lo};
    assign prod_fixed = neg_res ? -prod : prod;
    assign quo_fixed  = neg_res ? -acc_lo : acc_lo;
    assign rem_fixed  = neg_rem ? -acc_hi : acc_hi;

    assign bus.busy        = busy_q;
    assign bus.stall       = busy_q | (bus.start & ((state == IDLE) || (state == DONE)));
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

    // Flush during PREP/RUN/FIX drops the operation with HI/LO untouched; in
    // IDLE/DONE it only squashes a coincident start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            addend  <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dbz     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.hi_we) hi_q <= bus.wr_data;
                    if (bus.lo_we) lo_q <= bus.wr_data;
                    if (bus.start && !bus.flush) begin
                        is_div <= bus.op[1];
                        a_q    <= bus.operand_a;
                        b_q    <= bus.operand_b;
`ifdef MULDIV_SIGNED_EN
                        signed_q <= bus.op[0];
`endif
                        busy_q <= 1'b1;
                        state  <= PREP;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREP: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dbz     <= is_div && (b_q == '0);
                        acc_hi  <= '0;
                        acc_lo  <= is_div ? mag_a : mag_b;
                        addend  <= is_div ? mag_b : mag_a;
                        count   <= CW'(WIDTH);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        count <= count - 1'b1;
                        if (count == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            hi_q <= rem_fixed;
                            lo_q <= quo_fixed;
                        end else begin
                            hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fixed[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                        dbz_q  <= dbz;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
